ts_sync_lock: RTL and testbench

- Parametrised N-channel MPEG-2 TS sync recovery with lock/loss hysteresis and flywheel timing.
- Per channel, it hunts for SYNC_BYTE and verifies LOCK_COUNT consecutive syncs at PKT_LEN spacing before declaring lock.
- While locked, it marks packet starts at the expected position even when a sync byte is corrupted.
- It drops lock only after LOSS_COUNT consecutive missed syncs. It sits between the byte-stream inputs and the QoS/PID-processing stages.

---
 rtl/ts_sync_lock.sv | 148 ++++++++++++++
 tb/tb_ts_sync_lock.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ts_sync_lock.sv
// N-channel MPEG-2 TS sync recovery: hunt / verify / locked with flywheel timing.
// Each channel runs its own state machine; outputs are registered one cycle behind the input byte.
module ts_sync_lock #(
    parameter int          NUM_CH     = 4,
    parameter int          PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int          LOCK_COUNT = 3,
    parameter int          LOSS_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*8-1:0]   byte_in,
    input  logic [NUM_CH-1:0]     byte_valid,
    output logic [NUM_CH*8-1:0]   byte_out,
    output logic [NUM_CH-1:0]     valid_out,
    output logic [NUM_CH-1:0]     sop,
    output logic [NUM_CH-1:0]     locked,
    output logic [NUM_CH-1:0]     sync_err,
    output logic [NUM_CH-1:0]     lock_lost
);

    localparam int PW = $clog2(PKT_LEN);
    localparam int HW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [PW-1:0] pos_wrap(input logic [PW-1:0] p);
        return (p == PW'(PKT_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t          state_p0, state_nxt;
        logic [PW-1:0]   pos_p0, pos_nxt;
        logic [HW-1:0]   hits_p0, hits_nxt, hits_inc;
        logic [3:0]      miss_p0, miss_nxt, miss_inc;
        logic [7:0]      b;
        logic            v;
        logic            sop_nxt, err_nxt, lost_nxt;
        logic [7:0]      byte_p1;
        logic            vld_p1, sop_p1, lk_p1, err_p1, lost_p1;

        assign b        = byte_in[8*c +: 8];
        assign v        = byte_valid[c];
        assign hits_inc = hits_p0 + HW'(1);
        assign miss_inc = miss_p0 + 4'd1;

        always_comb begin
            state_nxt = state_p0;
            pos_nxt   = pos_p0;
            hits_nxt  = hits_p0;
            miss_nxt  = miss_p0;
            sop_nxt   = 1'b0;
            err_nxt   = 1'b0;
            lost_nxt  = 1'b0;
            case (state_p0)
                HUNT: begin
                    if (v) begin
                        pos_nxt = pos_wrap(pos_p0);
                        if (b == SYNC_BYTE) begin
                            state_nxt = VERIFY;
                            pos_nxt   = PW'(1);
                            hits_nxt  = HW'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (v) begin
                        pos_nxt = pos_wrap(pos_p0);
                        if (pos_p0 == '0) begin
                            if (b == SYNC_BYTE) begin
                                hits_nxt = hits_inc;
                                if (hits_inc == HW'(LOCK_COUNT)) begin
                                    state_nxt = LOCKED;
                                    miss_nxt  = '0;
                                    sop_nxt   = 1'b1;
                                end
                            end else begin
                                // The failing byte is not reconsidered as a fresh sync candidate
                                state_nxt = HUNT;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (v) begin
                        pos_nxt = pos_wrap(pos_p0);
                        if (pos_p0 == '0) begin
                            if (b == SYNC_BYTE) begin
                                sop_nxt  = 1'b1;
                                miss_nxt = '0;
                            end else begin
                                err_nxt  = 1'b1;
                                miss_nxt = miss_inc;
                                if (miss_inc == 4'(LOSS_COUNT)) begin
                                    state_nxt = HUNT;
                                    lost_nxt  = 1'b1;
                                end else begin
                                    // Flywheel: keep marking packet starts across a corrupted sync
                                    sop_nxt = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        // Stage p0 -> p1: state update and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state_p0 <= HUNT;
                pos_p0   <= '0;
                hits_p0  <= '0;
                miss_p0  <= '0;
                byte_p1  <= '0;
                vld_p1   <= 1'b0;
                sop_p1   <= 1'b0;
                lk_p1    <= 1'b0;
                err_p1   <= 1'b0;
                lost_p1  <= 1'b0;
            end else begin
                state_p0 <= state_nxt;
                pos_p0   <= pos_nxt;
                hits_p0  <= hits_nxt;
                miss_p0  <= miss_nxt;
                byte_p1  <= v ? b : 8'h00;
                vld_p1   <= v;
                sop_p1   <= sop_nxt;
                lk_p1    <= (state_nxt == LOCKED);
                err_p1   <= err_nxt;
                lost_p1  <= lost_nxt;
            end
        end

        assign byte_out[8*c +: 8] = byte_p1;
        assign valid_out[c]       = vld_p1;
        assign sop[c]             = sop_p1;
        assign locked[c]          = lk_p1;
        assign sync_err[c]        = err_p1;
        assign lock_lost[c]       = lost_p1;
    end

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed bench for ts_sync_lock: 4-channel lock/flywheel/loss scenarios, mid-packet reset,
// and a 204-byte single-channel instance fed with random valid gaps.
module tb_ts_sync_lock;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] byte_in;
    logic [3:0]  byte_valid;
    logic [31:0] byte_out;
    logic [3:0]  valid_out, sop, locked, sync_err, lock_lost;

    logic [7:0]  g_byte_in, g_byte_out;
    logic        g_valid, g_valid_out, g_sop, g_locked, g_sync_err, g_lock_lost;

    int n_cmp = 0;
    int n_err = 0;

    ts_sync_lock #(.NUM_CH(4), .PKT_LEN(188), .SYNC_BYTE(8'h47), .LOCK_COUNT(3), .LOSS_COUNT(3)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_out(byte_out), .valid_out(valid_out), .sop(sop), .locked(locked),
        .sync_err(sync_err), .lock_lost(lock_lost)
    );

    ts_sync_lock #(.NUM_CH(1), .PKT_LEN(204), .SYNC_BYTE(8'h47), .LOCK_COUNT(3), .LOSS_COUNT(3)) dut204 (
        .clk(clk), .rst(rst), .byte_in(g_byte_in), .byte_valid(g_valid),
        .byte_out(g_byte_out), .valid_out(g_valid_out), .sop(g_sop), .locked(g_locked),
        .sync_err(g_sync_err), .lock_lost(g_lock_lost)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int ch, input int idx, input bit plain);
        logic [7:0] fill;
        bit         at;
        fill = 8'(idx % 64);
        at   = (idx % 188) == 0;
        if (plain || ch == 0) return at ? 8'h47 : fill;
        if (ch == 1) begin
            if (idx == 0 || idx == 700) return 8'h47;
            if (idx == 188) return 8'h00;
            if (idx >= 200 && ((idx - 200) % 188) == 0) return 8'h47;
            return fill;
        end
        if (ch == 2) begin
            if (at) return (idx == 564 || idx == 940 || idx == 1128) ? 8'h46 : 8'h47;
            return fill;
        end
        if (at) return (idx == 564 || idx == 752 || idx == 940) ? 8'h46 : 8'h47;
        return fill;
    endfunction

    function automatic logic [3:0] exp_lk(input int idx);
        logic [3:0] e;
        e[0] = idx >= 376;
        e[1] = idx >= 576;
        e[2] = idx >= 376;
        e[3] = (idx >= 376 && idx < 940) || idx >= 1504;
        return e;
    endfunction

    function automatic logic [3:0] exp_sop(input int idx);
        logic [3:0] e;
        bit         at;
        at   = (idx % 188) == 0;
        e[0] = at && idx >= 376;
        e[1] = idx >= 576 && ((idx - 200) % 188) == 0;
        e[2] = at && idx >= 376;
        e[3] = at && ((idx >= 376 && idx < 940) || idx >= 1504);
        return e;
    endfunction

    function automatic logic [3:0] exp_err(input int idx);
        logic [3:0] e;
        e    = 4'b0000;
        e[2] = idx == 564 || idx == 940 || idx == 1128;
        e[3] = idx == 564 || idx == 752 || idx == 940;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_b;
        logic [7:0]  gb;
        bit          val, lk_e;
        int          vcnt, cyc;

        rst        = 1'b1;
        byte_in    = 32'h4747_4747;
        byte_valid = 4'hF;
        g_byte_in  = 8'h47;
        g_valid    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_out", byte_out, 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_sop", 32'(sop), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_g_out", {g_byte_out, 2'b00, g_valid_out, g_sop, g_locked, g_sync_err, g_lock_lost},
            32'h0);
        rst     = 1'b0;
        g_valid = 1'b0;

        for (int idx = 0; idx < 1650; idx++) begin
            for (int ch = 0; ch < 4; ch++) exp_b[8*ch +: 8] = gen(ch, idx, 1'b0);
            byte_in    = exp_b;
            byte_valid = 4'hF;
            @(posedge clk);
            #1;
            chk("byte_out", byte_out, exp_b);
            chk("valid_out", 32'(valid_out), 32'hF);
            chk("sop", 32'(sop), 32'(exp_sop(idx)));
            chk("locked", 32'(locked), 32'(exp_lk(idx)));
            chk("sync_err", 32'(sync_err), 32'(exp_err(idx)));
            chk("lock_lost", 32'(lock_lost), (idx == 940) ? 32'h8 : 32'h0);
        end

        rst        = 1'b1;
        byte_in    = 32'h4747_4747;
        byte_valid = 4'hF;
        @(posedge clk);
        #1;
        chk("midrst_byte_out", byte_out, 32'h0);
        chk("midrst_valid", 32'(valid_out), 32'h0);
        chk("midrst_sop", 32'(sop), 32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        chk("midrst_err", 32'(sync_err), 32'h0);
        chk("midrst_lost", 32'(lock_lost), 32'h0);
        rst = 1'b0;

        for (int idx = 0; idx < 400; idx++) begin
            for (int ch = 0; ch < 4; ch++) exp_b[8*ch +: 8] = gen(ch, idx, 1'b1);
            byte_in = exp_b;
            @(posedge clk);
            #1;
            chk("relock_sop", 32'(sop), (idx >= 376 && (idx % 188) == 0) ? 32'hF : 32'h0);
            chk("relock_locked", 32'(locked), (idx >= 376) ? 32'hF : 32'h0);
            chk("relock_err", 32'(sync_err | lock_lost), 32'h0);
        end

        byte_in    = 32'h4747_4747;
        byte_valid = 4'h0;
        vcnt       = 0;
        cyc        = 0;
        lk_e       = 1'b0;
        while (vcnt < 1000 && cyc < 6000) begin
            val = 1'($urandom_range(0, 1));
            gb  = ((vcnt % 204) == 0) ? 8'h47 : 8'(vcnt % 64);
            g_valid   = val;
            g_byte_in = val ? gb : 8'h47;
            @(posedge clk);
            #1;
            chk("gap_valid_out", 32'(g_valid_out), 32'(val));
            chk("gap_byte_out", 32'(g_byte_out), val ? 32'(gb) : 32'h0);
            chk("gap_sop", 32'(g_sop), 32'(val && (vcnt % 204) == 0 && vcnt >= 408));
            if (val) begin
                lk_e = vcnt >= 408;
                vcnt++;
            end
            chk("gap_locked", 32'(g_locked), 32'(lk_e));
            chk("gap_err", 32'({g_sync_err, g_lock_lost}), 32'h0);
            chk("idle_out", {byte_out[27:0], valid_out | sop}, 32'h0);
            chk("idle_locked", 32'(locked), 32'hF);
            cyc++;
        end
        chk("gap_budget", 32'(vcnt >= 1000), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
